pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Parametrised lock supervisor for 1..N_PLL rPLL instances in the HDMI TX clocking path. It drives each PLL's RESET input and synchronises the PLL LOCK outputs. It holds the downstream system reset until every lock has been stable for a programmable time. It retries unlocked PLLs on timeout, re-resets any PLL that loses lock in operation, and flags a sticky fault after too many retries.

Parameters:
N_PLL, 1, number of supervised PLLs (1..8)
PLL_RST_CYCLES, 16, cycles pll_reset is held per reset pulse (>=1)
LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK before a retry (>=2)
STABLE_CYCLES, 1024, consecutive all-locked cycles required before release (>=1)
MAX_RETRIES, 3, timeouts tolerated before FAULT (>=1)

Ports:
clkin  input  1  free-running reference clock (27 MHz board clock); every register is in this domain
reset  input  1  synchronous, active-high reset
pll_lock  input  N_PLL  raw LOCK from each PLL, asynchronous to clkin
pll_reset  output  N_PLL  per-PLL RESET drive, active-high
sys_reset  output  1  downstream reset, active-high, registered
locked_all  output  1  high while the FSM is in RUN
fault  output  1  sticky retry-exhaustion flag
retry_count  output  $clog2(MAX_RETRIES+1)  timeouts since the last RUN entry
state  output  3  encoded FSM state: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4

Behaviour:
- Clocking and reset: one clock (clkin). Reset is synchronous and active-high. All outputs are registered.
- Reset values: pll_reset all ones, sys_reset=1, locked_all=0, fault=0, retry_count=0, state=PLL_RST, all counters 0.
- Lock synchroniser: each pll_lock bit passes through a 2-FF synchroniser; lock_s is its output. The FSM only ever sees lock_s (2-cycle latency).
- rst_mask: N_PLL-bit register selecting which PLLs to reset. Set to all ones at reset.
- PLL_RST:
  - pll_reset = rst_mask; the bits outside the mask are 0.
  - Counts PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with pll_reset = 0.
- WAIT_LOCK:
  - Timer counts up.
  - If lock_s is all ones: go to STABLE and clear the timer.
  - Else, if the timer reaches LOCK_TIMEOUT-1:
    - if retry_count == MAX_RETRIES: go to FAULT;
    - otherwise increment retry_count, set rst_mask = ~lock_s (only the unlocked PLLs), and go to PLL_RST.
  - Lock arriving on the timeout cycle: lock wins; no retry.
- STABLE:
  - Counts consecutive cycles with lock_s all ones.
  - If any bit drops: return to WAIT_LOCK with the timer cleared; retry_count is unchanged.
  - When the count reaches STABLE_CYCLES: go to RUN.
- RUN:
  - Entry: sys_reset falls to 0, locked_all rises to 1, retry_count clears to 0.
  - Exit: any lock_s bit low triggers lock loss (unfiltered build). On the next edge: sys_reset=1, locked_all=0, rst_mask = ~lock_s, state=PLL_RST.
- FAULT:
  - pll_reset all ones, sys_reset=1, fault=1.
  - Held until reset. pll_lock is ignored.
- Release latency: with all raw locks high before WAIT_LOCK, sys_reset deasserts exactly STABLE_CYCLES+1 cycles after WAIT_LOCK entry.
- sys_reset is never low outside RUN.
- Reset mid-operation (any state): return to PLL_RST with all PLLs reset on the next edge. The synchroniser flops clear to 0.
- Counter widths: $clog2 of each bound, at least 1 bit. No counter wraps, because every counter is cleared on every state transition.

Optional Feature:
PLL_LOCK_FILTER_EN
- Defined: in RUN, lock loss is declared only after lock_s is not all ones for 4 consecutive cycles. Shorter dropouts are ignored and the filter counter clears on any all-ones cycle. STABLE and WAIT_LOCK are unaffected.
- Undefined: a single cycle with any lock_s bit low in RUN triggers lock loss. No filter logic is generated.

Test Plan:
Common configuration: N_PLL=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, unless a line says otherwise.
- Nominal bring-up: reset for 2 cycles; raw locks high from the start -> pll_reset=2'b11 for 4 cycles; sys_reset falls 9 cycles after WAIT_LOCK entry; locked_all=1, state=3.
- Partial timeout: pll_lock[0] high, pll_lock[1] held low -> at 32 cycles in WAIT_LOCK, pll_reset=2'b10 for 4 cycles; retry_count=1. Raise pll_lock[1] -> RUN, retry_count=0.
- Exhaustion: both locks low forever -> two retries, then after the third timeout state=4, fault=1, pll_reset=2'b11. Raising the locks has no effect until reset.
- STABLE glitch: drop pll_lock[0] for 1 cycle at STABLE count 5 -> state returns to 1, then re-enters STABLE; sys_reset stays 1 until 8 clean cycles have elapsed.
- Loss in RUN: drop pll_lock[1] for 1 cycle -> sys_reset=1 within 3 cycles of the raw drop, pll_reset=2'b10. With PLL_LOCK_FILTER_EN, a 3-cycle drop is ignored and a 4-cycle drop triggers lock loss.
- Reset mid-STABLE: assert reset at STABLE count 6 -> next edge state=0, pll_reset=2'b11, sys_reset=1, retry_count=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - supervises rPLL reset/lock sequencing and gates the downstream reset
// Optional RUN-state lock-loss glitch filter: define PLL_LOCK_FILTER_EN.
module pll_lock_supervisor #(
  parameter int N_PLL          = 1,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                               clkin,
  input  logic                               reset,
  input  logic [N_PLL-1:0]                   pll_lock,
  output logic [N_PLL-1:0]                   pll_reset,
  output logic                               sys_reset,
  output logic                               locked_all,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [2:0]                         state
);

  localparam int RCW = $clog2(MAX_RETRIES + 1);
  localparam int RW  = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int TW  = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
  localparam int SW  = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
  localparam int CW0 = (RW > TW) ? RW : TW;
  localparam int CW  = (CW0 > SW) ? CW0 : SW;

  localparam logic [CW-1:0]  RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]  TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]  STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_MAX   = RCW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t          st;
  logic [CW-1:0]   cnt;
  logic [N_PLL-1:0] rst_mask;
  logic [N_PLL-1:0] lock_m;
  logic [N_PLL-1:0] lock_s;
  logic            all_locked;
  logic            lock_lost;

  assign state      = st;
  assign all_locked = &lock_s;

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_m <= '0;
      lock_s <= '0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

`ifdef PLL_LOCK_FILTER_EN
  // Loss is declared on the 4th consecutive not-all-locked cycle in RUN.
  logic [1:0] filt_cnt;

  assign lock_lost = !all_locked && (filt_cnt == 2'd3);

  always_ff @(posedge clkin) begin
    if (reset || st != S_RUN || all_locked) begin
      filt_cnt <= 2'd0;
    end else if (filt_cnt != 2'd3) begin
      filt_cnt <= filt_cnt + 2'd1;
    end
  end
`else
  assign lock_lost = !all_locked;
`endif

  always_ff @(posedge clkin) begin
    if (reset) begin
      st          <= S_PLL_RST;
      cnt         <= '0;
      rst_mask    <= '1;
      pll_reset   <= '1;
      sys_reset   <= 1'b1;
      locked_all  <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
    end else begin
      case (st)
        S_PLL_RST: begin
          if (cnt == RST_LAST) begin
            st        <= S_WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= '0;
          end else begin
            cnt       <= cnt + 1'b1;
            pll_reset <= rst_mask;
          end
        end
        S_WAIT_LOCK: begin
          // A lock arriving on the timeout cycle takes priority over the retry.
          if (all_locked) begin
            st  <= S_STABLE;
            cnt <= '0;
          end else if (cnt == TO_LAST) begin
            cnt <= '0;
            if (retry_count == RETRY_MAX) begin
              st        <= S_FAULT;
              pll_reset <= '1;
              fault     <= 1'b1;
            end else begin
              st          <= S_PLL_RST;
              retry_count <= retry_count + 1'b1;
              rst_mask    <= ~lock_s;
              pll_reset   <= ~lock_s;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!all_locked) begin
            st  <= S_WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            st          <= S_RUN;
            cnt         <= '0;
            sys_reset   <= 1'b0;
            locked_all  <= 1'b1;
            retry_count <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Only the PLLs that actually dropped lock are re-reset.
          if (lock_lost) begin
            st         <= S_PLL_RST;
            cnt        <= '0;
            sys_reset  <= 1'b1;
            locked_all <= 1'b0;
            rst_mask   <= ~lock_s;
            pll_reset  <= ~lock_s;
          end
        end
        S_FAULT: begin
          pll_reset <= '1;
          sys_reset <= 1'b1;
          fault     <= 1'b1;
        end
        default: begin
          st         <= S_PLL_RST;
          cnt        <= '0;
          rst_mask   <= '1;
          pll_reset  <= '1;
          sys_reset  <= 1'b1;
          locked_all <= 1'b0;
        end
      endcase
    end
  end

endmodule
